// File: rtl/dll_phase_tracker.sv
// Early/late dithering phase tracker for the DLL correlator chain.
// Integrates demod magnitude in each arm and steps the center toward the larger one.
module dll_phase_tracker #(
  parameter logic [15:0] STEP     = 16'h0100,
  parameter logic [15:0] DITHER   = 16'h0400,
  parameter int          NAVG     = 2,
  parameter int          LOCK_TOL = 8
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic [7:0]        value,
  input  logic              rdy,
  input  logic              hold,
  output logic [15:0]       phase,
  output logic [15:0]       center,
  output logic [8+NAVG:0]   err,
  output logic              upd,
  output logic              lock
);

  localparam int AW = 8 + NAVG;
  localparam int EW = 9 + NAVG;

  typedef enum logic [2:0] {
    E_SETTLE,
    E_ACC,
    L_SETTLE,
    L_ACC,
    UPDATE
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [NAVG-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]      early_q, early_d;
  logic [AW-1:0]      late_q, late_d;
  logic [15:0]        center_q, center_d;
  logic [15:0]        phase_q, phase_d;
  logic [EW-1:0]      err_q, err_d;
  logic               upd_q, upd_d;
  logic [3:0]         lk_q, lk_d;
  logic               lock_q, lock_d;

  logic [AW-1:0]      acc_sum;
  logic               last;
  logic signed [EW-1:0] diff;
  logic [EW-1:0]      mag;
  logic               in_tol;
  logic [15:0]        ctr_nx;

  always_comb begin
    acc_sum = acc_q + AW'(value);
    last    = (cnt_q == '1);
    diff    = $signed({1'b0, late_q}) - $signed({1'b0, early_q});
    mag     = diff[EW-1] ? EW'(-diff) : EW'(diff);
    in_tol  = (mag <= EW'(LOCK_TOL));

    ctr_nx = center_q;
    if (diff[EW-1])
      ctr_nx = center_q - STEP;
    else if (diff != '0)
      ctr_nx = center_q + STEP;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    early_d  = early_q;
    late_d   = late_q;
    center_d = center_q;
    phase_d  = phase_q;
    err_d    = err_q;
    upd_d    = 1'b0;
    lk_d     = lk_q;
    unique case (state_q)
      E_SETTLE: begin
        if (rdy) begin
          state_d = E_ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      E_ACC: begin
        if (rdy) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            early_d = acc_sum;
            phase_d = center_q + DITHER;
            state_d = L_SETTLE;
          end
        end
      end
      L_SETTLE: begin
        if (rdy) begin
          state_d = L_ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      L_ACC: begin
        if (rdy) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            late_d  = acc_sum;
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        err_d   = diff;
        state_d = E_SETTLE;
        if (!hold) begin
          center_d = ctr_nx;
          upd_d    = 1'b1;
          if (in_tol)
            lk_d = (lk_q == 4'hF) ? 4'hF : lk_q + 4'd1;
          else
            lk_d = 4'd0;
        end
        phase_d = (hold ? center_q : ctr_nx) - DITHER;
      end
      default: state_d = E_SETTLE;
    endcase
    lock_d = (lk_d == 4'hF);
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q  <= E_SETTLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      early_q  <= '0;
      late_q   <= '0;
      center_q <= 16'h0000;
      phase_q  <= 16'h0000 - DITHER;
      err_q    <= '0;
      upd_q    <= 1'b0;
      lk_q     <= 4'd0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      early_q  <= early_d;
      late_q   <= late_d;
      center_q <= center_d;
      phase_q  <= phase_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      lk_q     <= lk_d;
      lock_q   <= lock_d;
    end
  end

  assign phase  = phase_q;
  assign center = center_q;
  assign err    = err_q;
  assign upd    = upd_q;
  assign lock   = lock_q;

endmodule

// File: tb/tb_dll_phase_tracker.sv
// Bench for dll_phase_tracker: vector table of arm patterns plus a
// scoreboard of expected updates checked whenever upd pulses.
module tb_dll_phase_tracker;

  localparam logic [15:0] STEP   = 16'h0100;
  localparam logic [15:0] DITHER = 16'h0400;
  localparam int          NAVG   = 2;
  localparam int          TOL    = 8;

  logic              clk = 1'b0;
  logic              rst_in = 1'b1;
  logic [7:0]        value = 8'd0;
  logic              rdy = 1'b0;
  logic              hold = 1'b0;
  logic [15:0]       phase;
  logic [15:0]       center;
  logic signed [10:0] err;
  logic              upd;
  logic              lock;

  dll_phase_tracker #(
    .STEP(STEP), .DITHER(DITHER), .NAVG(NAVG), .LOCK_TOL(TOL)
  ) dut (
    .clk(clk), .rst_in(rst_in), .value(value), .rdy(rdy),
    .hold(hold), .phase(phase), .center(center), .err(err),
    .upd(upd), .lock(lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] se;
    logic [7:0] e;
    logic [7:0] sl;
    logic [7:0] l;
    logic       hd;
    int         exp_err;
  } vec_t;

  typedef struct {
    int          err;
    logic [15:0] center;
    logic        lock;
  } exp_t;

  exp_t        sbq[$];
  vec_t        tbl[9];
  int          total = 0;
  int          bad = 0;
  logic [15:0] center_m = 16'h0000;
  int          lkc_m = 0;

  function automatic int u16(logic [15:0] x);
    return int'({16'b0, x});
  endfunction

  task automatic check(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t ex;
    if (upd) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL upd_unexpected: got 1 want 0");
      end else begin
        ex = sbq.pop_front();
        check("upd_err", int'(err), ex.err);
        check("upd_center", u16(center), u16(ex.center));
        check("upd_lock", int'(lock), int'(ex.lock));
        check("upd_phase", u16(phase), u16(ex.center - DITHER));
      end
    end
  end

  task automatic put(input logic [7:0] v);
    value = v;
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    value = 8'd0;
  endtask

  task automatic run_update(input vec_t v);
    exp_t ex;
    hold = v.hd;
    check("phase_early", u16(phase), u16(center_m - DITHER));
    put(v.se);
    repeat (4) put(v.e);
    check("phase_late", u16(phase), u16(center_m + DITHER));
    put(v.sl);
    repeat (4) put(v.l);
    if (!v.hd) begin
      if (v.exp_err > 0) center_m = center_m + STEP;
      else if (v.exp_err < 0) center_m = center_m - STEP;
      if (v.exp_err <= TOL && v.exp_err >= -TOL)
        lkc_m = (lkc_m == 15) ? 15 : lkc_m + 1;
      else
        lkc_m = 0;
      ex.err = v.exp_err;
      ex.center = center_m;
      ex.lock = (lkc_m == 15);
      sbq.push_back(ex);
    end
    @(posedge clk);
    #1;
    if (v.hd) begin
      check("hold_upd", int'(upd), 0);
      check("hold_err", int'(err), v.exp_err);
      check("hold_center", u16(center), u16(center_m));
      check("hold_lock", int'(lock), int'(lkc_m == 15));
    end
    hold = 1'b0;
  endtask

  task automatic check_reset(string tag);
    check({tag, "_phase"}, u16(phase), u16(16'hFC00));
    check({tag, "_center"}, u16(center), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_upd"}, int'(upd), 0);
    check({tag, "_lock"}, int'(lock), 0);
  endtask

  initial begin
    vec_t rv;
    tbl[0] = '{8'd50, 8'd50, 8'd50, 8'd50, 1'b0, 0};
    tbl[1] = '{8'd10, 8'd100, 8'd10, 8'd20, 1'b0, -320};
    tbl[2] = '{8'd10, 8'd100, 8'd10, 8'd20, 1'b0, -320};
    tbl[3] = '{8'd255, 8'd10, 8'd255, 8'd10, 1'b0, 0};
    tbl[4] = '{8'd0, 8'd0, 8'd0, 8'd200, 1'b1, 800};
    tbl[5] = '{8'd0, 8'd0, 8'd0, 8'd200, 1'b0, 800};
    tbl[6] = '{8'd7, 8'd30, 8'd7, 8'd32, 1'b0, 8};
    tbl[7] = '{8'd7, 8'd32, 8'd7, 8'd30, 1'b0, -8};
    tbl[8] = '{8'd0, 8'd30, 8'd0, 8'd33, 1'b0, 12};

    rst_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_in = 1'b0;
    check_reset("rst");

    // balanced input: lock should appear on the 15th update
    for (int i = 0; i < 16; i++)
      run_update(tbl[0]);
    for (int i = 1; i < 9; i++)
      run_update(tbl[i]);

    // reset in the middle of the late arm
    put(8'd200);
    repeat (4) put(8'd200);
    put(8'd200);
    put(8'd200);
    put(8'd200);
    rst_in = 1'b1;
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    center_m = 16'h0000;
    lkc_m = 0;
    check_reset("midrst");
    rv = '{8'd0, 8'd5, 8'd0, 8'd9, 1'b0, 16};
    run_update(rv);

    repeat (4) @(posedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL upd_missing: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
